// File: rtl/alu_pipe_if.sv
// Handshake bus for alu_pipe: operand/opcode side (in_*) and result side (out_*).
// The master drives operations and consumes results; the slave is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, ctrl, x, y, out_ready,
    input  in_ready, out_valid, out, carry, zero, err
  );

  modport slave (
    input  in_valid, ctrl, x, y, out_ready,
    output in_ready, out_valid, out, carry, zero, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked, registered ALU. Single-cycle ops complete on the accept edge;
// MUL runs a WIDTH-cycle unsigned shift-add before its result is presented.
// A result is held until the consumer takes it; a new op can be accepted on
// that same edge, giving one op per cycle for single-cycle opcodes.
module alu_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_NOT  = 4'h4,
    OP_XOR  = 4'h5,
    OP_XNOR = 4'h6,
    OP_SLL  = 4'h7,
    OP_SRL  = 4'h8,
    OP_ASR1 = 4'h9,
    OP_ROL1 = 4'hA,
    OP_ROR1 = 4'hB,
    OP_EQ   = 4'hC,
    OP_MUL  = 4'hD
  } op_e;

  state_e             state;
  logic [WIDTH-1:0]   out_q;
  logic               carry_q;
  logic               zero_q;
  logic               err_q;

  // Multiplier datapath: mcand shifts left, mplier shifts right, acc sums.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  logic               accept;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_e;

  // In DONE the slot frees up as soon as the consumer takes the result.
  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign mul_sum = acc + (mplier[0] ? mcand : '0);

  // Single-cycle result for the opcode currently on the bus.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    res   = '0;
    res_c = 1'b0;
    res_e = 1'b0;
    case (bus.ctrl)
      OP_ADD:  {res_c, res} = {1'b0, bus.x} + {1'b0, bus.y};
      OP_SUB:  {res_c, res} = {1'b0, bus.x} - {1'b0, bus.y};
      OP_AND:  res = bus.x & bus.y;
      OP_OR:   res = bus.x | bus.y;
      OP_NOT:  res = ~bus.x;
      OP_XOR:  res = bus.x ^ bus.y;
      OP_XNOR: res = ~(bus.x ^ bus.y);
      OP_SLL:  res = bus.y << bus.x[SHW-1:0];
      OP_SRL:  res = bus.y >> bus.x[SHW-1:0];
      OP_ASR1: res = {bus.x[WIDTH-1], bus.x[WIDTH-1:1]};
      OP_ROL1: res = {bus.x[WIDTH-2:0], bus.x[WIDTH-1]};
      OP_ROR1: res = {bus.x[0], bus.x[WIDTH-1:1]};
      OP_EQ:   res = WIDTH'(bus.x == bus.y);
      OP_MUL:  res = '0;
      default: res_e = 1'b1;
    endcase
  end

  // Control FSM, result registers and multiplier iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (bus.ctrl == OP_MUL) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, bus.x};
              mplier <= bus.y;
              cnt    <= '0;
              state  <= BUSY;
            end else begin
              out_q   <= res;
              carry_q <= res_c;
              zero_q  <= (res == '0);
              err_q   <= res_e;
              state   <= DONE;
            end
          end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            out_q   <= mul_sum[WIDTH-1:0];
            carry_q <= |mul_sum[2*WIDTH-1:WIDTH];
            zero_q  <= (mul_sum[WIDTH-1:0] == '0);
            err_q   <= 1'b0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: a table of hand-computed vectors pushed
// through a scoreboard, plus directed sequences for latency, back-to-back,
// backpressure, reset abort and a WIDTH=16 instance.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8))  bus ();
  alu_pipe_if #(.WIDTH(16)) bus16 ();

  alu_pipe #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] out;
    logic       carry;
    logic       err;
  } exp_t;

  typedef struct {
    logic [3:0] ctrl;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] out;
    logic       carry;
    logic       err;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Scoreboard: compare each result as it is handed over (valid && ready before the edge).
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        bound_fail("unexpected_result");
      end else begin
        mon_e = sb.pop_front();
        check("sb_out",   bus.out,   mon_e.out);
        check("sb_carry", bus.carry, mon_e.carry);
        check("sb_zero",  bus.zero,  mon_e.out == 8'h00);
        check("sb_err",   bus.err,   mon_e.err);
      end
    end
  end

  // Drive one op and hold it until accepted; operands are scrambled afterwards.
  task automatic send(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eo, input logic ec, input logic ee,
                      input bit track, output int waits);
    bus.ctrl     = c;
    bus.x        = a;
    bus.y        = b;
    bus.in_valid = 1'b1;
    if (track) sb.push_back('{out: eo, carry: ec, err: ee});
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits >= 64) begin
        bound_fail("accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.ctrl     = 4'($urandom);
    bus.x        = 8'($urandom);
    bus.y        = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      n++;
      if (n >= 100) begin
        bound_fail("drain_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] o, input logic cy, input logic e);
    vecs.push_back('{ctrl: c, x: a, y: b, out: o, carry: cy, err: e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    int late;

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.ctrl       = 4'h0;
    bus.x          = 8'h00;
    bus.y          = 8'h00;
    bus.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.ctrl      = 4'h0;
    bus16.x         = 16'h0000;
    bus16.y         = 16'h0000;
    bus16.out_ready = 1'b1;

    // Vector table: {ctrl, x, y, out, carry, err}, hand-computed for WIDTH=8.
    add_vec(4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);  // ADD wrap
    add_vec(4'h0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);  // ADD
    add_vec(4'h1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);  // SUB borrow
    add_vec(4'h1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);  // SUB
    add_vec(4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);  // AND
    add_vec(4'h3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0);  // OR
    add_vec(4'h4, 8'h0F, 8'h99, 8'hF0, 1'b0, 1'b0);  // NOT x
    add_vec(4'h5, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0);  // XOR
    add_vec(4'h6, 8'hAA, 8'hFF, 8'hAA, 1'b0, 1'b0);  // XNOR
    add_vec(4'h7, 8'h03, 8'h81, 8'h08, 1'b0, 1'b0);  // SLL
    add_vec(4'h8, 8'h04, 8'hF0, 8'h0F, 1'b0, 1'b0);  // SRL
    add_vec(4'h8, 8'h0B, 8'h80, 8'h10, 1'b0, 1'b0);  // SRL uses x[2:0] only
    add_vec(4'h9, 8'h81, 8'h00, 8'hC0, 1'b0, 1'b0);  // ASR1
    add_vec(4'hA, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0);  // ROL1
    add_vec(4'hB, 8'h01, 8'h00, 8'h80, 1'b0, 1'b0);  // ROR1
    add_vec(4'hC, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0);  // EQ true
    add_vec(4'hC, 8'h5A, 8'h5B, 8'h00, 1'b0, 1'b0);  // EQ false
    add_vec(4'hD, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0);  // MUL
    add_vec(4'hD, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0);  // MUL overflow, zero
    add_vec(4'hD, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);  // MUL max
    add_vec(4'hD, 8'h00, 8'h37, 8'h00, 1'b0, 1'b0);  // MUL by zero
    add_vec(4'hF, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1);  // reserved
    add_vec(4'hE, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);  // reserved
    add_vec(4'hA, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0);  // ROL1 clears err

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out",       bus.out,       8'h00);
    check("rst_carry",     bus.carry,     1'b0);
    check("rst_zero",      bus.zero,      1'b0);
    check("rst_err",       bus.err,       1'b0);
    @(posedge clk);
    #1;

    // Single-cycle latency: result visible right after the accept edge.
    send(4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, w);
    @(negedge clk);
    check("add_latency_valid", bus.out_valid, 1'b1);
    check("add_latency_out",   bus.out,       8'h00);
    check("add_latency_zero",  bus.zero,      1'b1);
    drain();

    // SUB then EQ back-to-back: EQ accepted on the edge that hands over SUB.
    send(4'h1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, w);
    send(4'hC, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b1, w);
    check("b2b_no_wait", w, 0);
    @(negedge clk);
    check("b2b_eq_out", bus.out, 8'h01);
    drain();

    // Table run, back-to-back through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].ctrl, vecs[i].x, vecs[i].y, vecs[i].out, vecs[i].carry, vecs[i].err, 1'b1, w);
    end
    drain();

    // MUL latency: in_ready low for WIDTH cycles, result after edge k+WIDTH.
    send(4'hD, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, w);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      check("mul_busy_in_ready", bus.in_ready, 1'b0);
      n++;
      if (n >= 20) begin
        bound_fail("mul_timeout");
        break;
      end
    end
    check("mul_latency", n, 8);
    drain();

    // Backpressure: result held while out_ready is low.
    bus.out_ready = 1'b0;
    send(4'h7, 8'h03, 8'h81, 8'h08, 1'b0, 1'b0, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",    bus.out_valid, 1'b1);
      check("bp_out",      bus.out,       8'h08);
      check("bp_in_ready", bus.in_ready,  1'b0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Reset asserted at the third edge of a MUL: no result may appear.
    send(4'hD, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_in_ready",  bus.in_ready,  1'b1);
    check("abort_out",       bus.out,       8'h00);
    check("abort_carry",     bus.carry,     1'b0);
    check("abort_err",       bus.err,       1'b0);
    late = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) late++;
    end
    check("abort_no_late_result", late, 0);
    @(posedge clk);
    #1;
    // Fresh MUL after the abort starts from a cleared accumulator.
    send(4'hD, 8'h03, 8'h05, 8'h0F, 1'b0, 1'b0, 1'b1, w);
    drain();

    // WIDTH=16 instance: ASR1 and a 16-bit MUL.
    bus16.ctrl     = 4'h9;
    bus16.x        = 16'h8000;
    bus16.y        = 16'h0000;
    bus16.in_valid = 1'b1;
    @(negedge clk);
    check("w16_in_ready", bus16.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    @(negedge clk);
    check("w16_asr_valid", bus16.out_valid, 1'b1);
    check("w16_asr_out",   bus16.out,       16'hC000);
    check("w16_asr_err",   bus16.err,       1'b0);
    @(posedge clk);
    #1;
    bus16.ctrl     = 4'hD;
    bus16.x        = 16'h0100;
    bus16.y        = 16'h0101;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    bus16.x        = 16'hFFFF;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus16.out_valid) break;
      n++;
      if (n >= 40) begin
        bound_fail("w16_mul_timeout");
        break;
      end
    end
    check("w16_mul_latency", n, 16);
    check("w16_mul_out",     bus16.out,   16'h0100);
    check("w16_mul_carry",   bus16.carry, 1'b1);
    check("w16_mul_zero",    bus16.zero,  1'b0);
    @(posedge clk);
    #1;

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
